// File: rtl/word_aligner.sv
// rtl/word_aligner.sv - serial-to-10-bit word aligner with comma-based lock/verify/loss FSM

module word_aligner #(
   parameter logic [9:0] COMMA    = 10'b0011111010,
   parameter int         LOCK_CNT = 3,
   parameter int         LOSS_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_in,
   input  logic       realign,
   output logic [9:0] word_out,
   output logic       word_valid,
   output logic       word_is_comma,
   output logic       locked,
   output logic       align_err
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

   state_t     state_q, state_d;
   // Only the 9 most recent bits need storing: the 10th comes straight from serial_in.
   logic [8:0] sreg_q, sreg_d;
   logic [3:0] phase_q, phase_d;
   logic [3:0] hit_cnt_q, hit_cnt_d;
   logic [3:0] miss_cnt_q, miss_cnt_d;
   logic [9:0] word_out_q, word_out_d;
   logic       word_valid_q, word_valid_d;
   logic       word_is_comma_q, word_is_comma_d;
   logic       locked_q, locked_d;
   logic       align_err_q, align_err_d;

   logic [9:0] window;
   logic       hit;
   logic       boundary;

   assign window   = {sreg_q, serial_in};
   assign hit      = (window == COMMA);
   assign boundary = (phase_q == 4'd9);

   // Next-state logic: realign beats loss-of-lock, which beats word output, which beats hit detection.
   always_comb begin
      state_d         = state_q;
      sreg_d          = window[8:0];
      phase_d         = boundary ? 4'd0 : phase_q + 4'd1;
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      word_out_d      = word_out_q;
      word_valid_d    = 1'b0;
      word_is_comma_d = word_is_comma_q;
      align_err_d     = 1'b0;

      if (realign) begin
         state_d     = HUNT;
         phase_d     = 4'd0;
         hit_cnt_d   = 4'd0;
         miss_cnt_d  = 4'd0;
         align_err_d = (state_q == LOCKED);
      end else begin
         unique case (state_q)
            HUNT: begin
               if (hit) begin
                  state_d   = VERIFY;
                  phase_d   = 4'd0;
                  hit_cnt_d = 4'd1;
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (hit) begin
                     if (hit_cnt_q + 4'd1 == LOCK_TGT) begin
                        state_d         = LOCKED;
                        hit_cnt_d       = 4'd0;
                        miss_cnt_d      = 4'd0;
                        word_out_d      = window;
                        word_is_comma_d = 1'b1;
                        word_valid_d    = 1'b1;
                     end else begin
                        hit_cnt_d = hit_cnt_q + 4'd1;
                     end
                  end else begin
                     state_d   = HUNT;
                     hit_cnt_d = 4'd0;
                  end
               end else if (hit) begin
                  // A comma on a different phase restarts verification there.
                  phase_d   = 4'd0;
                  hit_cnt_d = 4'd1;
               end
            end
            LOCKED: begin
               if (hit && !boundary) begin
                  if (miss_cnt_q == LOSS_LAST) begin
                     state_d     = HUNT;
                     align_err_d = 1'b1;
                     miss_cnt_d  = 4'd0;
                     hit_cnt_d   = 4'd0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 4'd1;
                  end
               end else if (boundary) begin
                  word_out_d      = window;
                  word_is_comma_d = hit;
                  word_valid_d    = 1'b1;
                  if (hit) begin
                     miss_cnt_d = 4'd0;
                  end
               end
            end
            default: begin
               state_d    = HUNT;
               hit_cnt_d  = 4'd0;
               miss_cnt_d = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= HUNT;
         sreg_q          <= '0;
         phase_q         <= '0;
         hit_cnt_q       <= '0;
         miss_cnt_q      <= '0;
         word_out_q      <= '0;
         word_valid_q    <= 1'b0;
         word_is_comma_q <= 1'b0;
         locked_q        <= 1'b0;
         align_err_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         sreg_q          <= sreg_d;
         phase_q         <= phase_d;
         hit_cnt_q       <= hit_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
         word_out_q      <= word_out_d;
         word_valid_q    <= word_valid_d;
         word_is_comma_q <= word_is_comma_d;
         locked_q        <= locked_d;
         align_err_q     <= align_err_d;
      end
   end

   assign word_out      = word_out_q;
   assign word_valid    = word_valid_q;
   assign word_is_comma = word_is_comma_q;
   assign locked        = locked_q;
   assign align_err     = align_err_q;

endmodule

// File: tb/tb_word_aligner.sv
// tb/tb_word_aligner.sv - directed self-checking bench for word_aligner

module tb_word_aligner;

   localparam logic [9:0] K = 10'h0FA;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_in;
   logic       realign;
   logic [9:0] word_out;
   logic       word_valid;
   logic       word_is_comma;
   logic       locked;
   logic       align_err;

   word_aligner dut (
      .clk           (clk),
      .reset         (reset),
      .serial_in     (serial_in),
      .realign       (realign),
      .word_out      (word_out),
      .word_valid    (word_valid),
      .word_is_comma (word_is_comma),
      .locked        (locked),
      .align_err     (align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] din;
      logic [9:0] exp_out;
      logic       exp_comma;
   } vec_t;

   vec_t tbl [0:5];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nv     = 0;
   int ne     = 0;
   int last_strobe = 0;
   int prev_strobe = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bit per clock; outputs are sampled 1 time unit after the edge.
   task automatic send_bit(input logic b, input logic rl);
      serial_in = b;
      realign   = rl;
      @(posedge clk);
      #1;
      realign = 1'b0;
      cyc++;
      if (word_valid) begin
         nv++;
         last_strobe = cyc;
      end
      if (align_err) ne++;
   endtask

   task automatic send_word(input logic [9:0] w, input logic rl_on_lsb);
      for (int i = 9; i >= 0; i--) begin
         send_bit(w[i], rl_on_lsb && (i == 0));
      end
   endtask

   initial begin
      tbl[0] = '{10'h2A5, 10'h2A5, 1'b0};
      tbl[1] = '{10'h155, 10'h155, 1'b0};
      tbl[2] = '{10'h0FA, 10'h0FA, 1'b1};
      tbl[3] = '{10'h000, 10'h000, 1'b0};
      tbl[4] = '{10'h3C3, 10'h3C3, 1'b0};
      tbl[5] = '{10'h0FA, 10'h0FA, 1'b1};

      reset     = 1'b1;
      serial_in = 1'b0;
      realign   = 1'b0;

      // Reset held two cycles with random data.
      for (int i = 0; i < 2; i++) begin
         send_bit(1'($urandom_range(0, 1)), 1'b0);
         check("reset_outputs", {word_out, word_valid, word_is_comma, locked, align_err}, 32'h0);
      end
      reset = 1'b0;
      nv = 0;
      for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0);
      check("post_reset_no_valid", nv, 0);
      check("post_reset_unlocked", locked, 0);

      // Lock on three commas.
      for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
      nv = 0;
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      check("lock_not_early", {nv[7:0], 7'd0, locked}, 32'h0);
      send_word(K, 1'b0);
      check("lock_strobe_count", nv, 1);
      check("lock_strobe_last_bit", word_valid, 1);
      check("lock_word_out", word_out, 32'h0FA);
      check("lock_is_comma", word_is_comma, 1);
      check("lock_locked", locked, 1);

      // Data words while locked: one strobe per word, 10 cycles apart.
      prev_strobe = last_strobe;
      for (int i = 0; i < 6; i++) begin
         nv = 0;
         send_word(tbl[i].din, 1'b0);
         check("tbl_strobe_count", nv, 1);
         check("tbl_spacing", last_strobe - prev_strobe, 10);
         check("tbl_word_out", word_out, {22'd0, tbl[i].exp_out});
         check("tbl_is_comma", word_is_comma, {31'd0, tbl[i].exp_comma});
         check("tbl_locked", locked, 1);
         prev_strobe = last_strobe;
      end

      // Slip by three bits, then four off-boundary commas drop lock.
      nv = 0;
      ne = 0;
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_word(K, 1'b0);
      check("loss_no_err_yet", ne, 0);
      check("loss_still_locked", locked, 1);
      check("loss_strobes_shifted", nv, 3);
      check("loss_strobe_not_comma", word_is_comma, 0);
      send_word(K, 1'b0);
      check("loss_err_count", ne, 1);
      check("loss_err_on_lsb", align_err, 1);
      check("loss_unlocked", locked, 0);
      nv = 0;
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      check("relock_not_early", locked, 0);
      send_word(K, 1'b0);
      check("relock_locked", locked, 1);
      check("relock_strobe", {word_valid, word_out}, {21'd0, 1'b1, K});

      // Realign while locked.
      send_bit(1'b0, 1'b1);
      check("realign_unlocked", locked, 0);
      check("realign_err", align_err, 1);
      send_bit(1'b0, 1'b0);
      check("realign_err_one_cycle", align_err, 0);

      // Realign coincident with a comma hit in HUNT: that hit is ignored.
      nv = 0;
      send_word(K, 1'b1);
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      check("realign_hit_ignored", {nv[7:0], 7'd0, locked}, 32'h0);
      send_word(K, 1'b0);
      check("realign_then_lock", locked, 1);

      // Verify failure: two commas then data returns to HUNT.
      send_bit(1'b0, 1'b1);
      nv = 0;
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      send_word(10'h2A5, 1'b0);
      check("vfail_no_lock", {nv[7:0], 7'd0, locked}, 32'h0);
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      check("vfail_then_lock", locked, 1);
      check("vfail_then_strobes", nv, 1);

      // Reset while locked abandons alignment silently.
      reset = 1'b1;
      ne = 0;
      send_bit(1'b1, 1'b0);
      reset = 1'b0;
      check("reset_locked_state", {word_valid, locked, align_err}, 32'h0);
      check("reset_no_err", ne, 0);
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      send_word(K, 1'b0);
      check("reset_then_lock", locked, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
